ysyx_25040109_lsu: RTL and testbench

YSYX_25040109_LSU -- requirements
Module: ysyx_25040109_lsu

---
 rtl/ysyx_25040109_pkg.sv | 62 ++++++
 rtl/ysyx_25040109_lsu_if.sv | 36 +++
 rtl/ysyx_25040109_lsu_ext.sv | 28 ++
 rtl/ysyx_25040109_lsu.sv | 102 ++++++++++
 tb/tb_ysyx_25040109_lsu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25040109_pkg.sv
// Shared LSU encodings: RV32 funct3 width codes, dmem write-length codes, FSM states,
// the captured request record and small decode helpers.
package ysyx_25040109_pkg;

   localparam logic [2:0] Funct3B  = 3'b000;
   localparam logic [2:0] Funct3H  = 3'b001;
   localparam logic [2:0] Funct3W  = 3'b010;
   localparam logic [2:0] Funct3Bu = 3'b100;
   localparam logic [2:0] Funct3Hu = 3'b101;

   localparam logic [2:0] WlenNone = 3'b000;
   localparam logic [2:0] WlenB    = 3'b001;
   localparam logic [2:0] WlenH    = 3'b010;
   localparam logic [2:0] WlenW    = 3'b100;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StStore = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   typedef struct packed {
      logic        wen;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   // Unsigned variants exist only for loads.
   function automatic logic funct3_legal(input logic wen, input logic [2:0] funct3);
      case (funct3)
         Funct3B, Funct3H, Funct3W: return 1'b1;
         Funct3Bu, Funct3Hu:        return !wen;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3[1:0])
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] align_addr(input logic [2:0] funct3, input logic [31:0] addr);
      case (funct3[1:0])
         2'b01:   return {addr[31:1], 1'b0};
         2'b10:   return {addr[31:2], 2'b00};
         default: return addr;
      endcase
   endfunction

   function automatic logic [2:0] wlen_of(input logic [2:0] funct3);
      case (funct3)
         Funct3B: return WlenB;
         Funct3H: return WlenH;
         Funct3W: return WlenW;
         default: return WlenNone;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_if.sv
// Core request/response channel plus data-memory port of the LSU.
interface ysyx_25040109_lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [31:0] dmem_raddr;
   logic        dmem_ren;
   logic [31:0] dmem_rdata;
   logic [31:0] dmem_waddr;
   logic [31:0] dmem_wdata;
   logic [2:0]  dmem_wlen;
   logic        dmem_wen;

   modport slave (
      input  req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready, dmem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output dmem_raddr, dmem_ren, dmem_waddr, dmem_wdata, dmem_wlen, dmem_wen
   );

   modport master (
      output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready, dmem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  dmem_raddr, dmem_ren, dmem_waddr, dmem_wdata, dmem_wlen, dmem_wen
   );

endinterface

// File: rtl/ysyx_25040109_lsu_ext.sv
// Load data alignment and extension: picks the addressed lane out of a memory word
// and sign/zero-extends it according to funct3.
module ysyx_25040109_lsu_ext
   import ysyx_25040109_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      result_o = '0;
      case (funct3_i)
         Funct3B:  result_o = {{24{shifted[7]}}, shifted[7:0]};
         Funct3H:  result_o = {{16{shifted[15]}}, shifted[15:0]};
         Funct3W:  result_o = shifted;
         Funct3Bu: result_o = {24'h0, shifted[7:0]};
         Funct3Hu: result_o = {16'h0, shifted[15:0]};
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Single-outstanding load/store unit: accepts one core request, performs a one-cycle
// dmem access (or reports an error), then holds the response until the core takes it.
module ysyx_25040109_lsu
   import ysyx_25040109_pkg::*;
#(
   parameter int unsigned MISALIGN_ERR = 1
) (
   input logic                clk,
   input logic                rst,
   ysyx_25040109_lsu_if.slave bus
);

   localparam bit ErrOnMisalign = (MISALIGN_ERR != 0);

   logic [1:0]  state_q, state_d;
   lsu_req_t    req_q, req_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] load_result;
   logic        req_bad;

   assign req_bad = !funct3_legal(bus.req_wen, bus.req_funct3) ||
                    (ErrOnMisalign && misaligned(bus.req_funct3, bus.req_addr[1:0]));

   ysyx_25040109_lsu_ext u_ext (
      .rdata_i  (bus.dmem_rdata),
      .offset_i (req_q.addr[1:0]),
      .funct3_i (req_q.funct3),
      .result_o (load_result)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               req_d.wen    = bus.req_wen;
               req_d.funct3 = bus.req_funct3;
               req_d.wdata  = bus.req_wdata;
               // With errors disabled the access silently snaps to natural alignment.
               req_d.addr   = ErrOnMisalign ? bus.req_addr
                                            : align_addr(bus.req_funct3, bus.req_addr);
               rdata_d      = '0;
               err_d        = req_bad;
               if (req_bad) begin
                  state_d = StResp;
               end else begin
                  state_d = bus.req_wen ? StStore : StLoad;
               end
            end
         end
         StLoad: begin
            rdata_d = load_result;
            err_d   = 1'b0;
            state_d = StResp;
         end
         StStore: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = StResp;
         end
         StResp: begin
            if (bus.resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Every dmem strobe is a pure state decode so an async reset kills it at once.
   assign bus.req_ready  = (state_q == StIdle) && !rst;
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign bus.dmem_ren   = (state_q == StLoad);
   assign bus.dmem_raddr = bus.dmem_ren ? {req_q.addr[31:2], 2'b00} : '0;

   assign bus.dmem_wen   = (state_q == StStore);
   assign bus.dmem_waddr = bus.dmem_wen ? req_q.addr : '0;
   assign bus.dmem_wdata = bus.dmem_wen ? req_q.wdata : '0;
   assign bus.dmem_wlen  = bus.dmem_wen ? wlen_of(req_q.funct3) : WlenNone;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Bench for the LSU: directed corner cases plus random traffic against a byte-array model.
module tb_ysyx_25040109_lsu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   logic [7:0]  ref_mem [0:1023];
   int          wr_cnt = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;
   logic [2:0]  last_wlen = '0;

   ysyx_25040109_lsu_if bus ();

   ysyx_25040109_lsu #(.MISALIGN_ERR(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [9:0] rbase;
   assign rbase = {bus.dmem_raddr[9:2], 2'b00};
   assign bus.dmem_rdata = {ref_mem[rbase + 10'd3], ref_mem[rbase + 10'd2],
                            ref_mem[rbase + 10'd1], ref_mem[rbase]};

   always @(posedge clk) begin
      if (bus.dmem_wen) begin
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= bus.dmem_waddr;
         last_wdata <= bus.dmem_wdata;
         last_wlen  <= bus.dmem_wlen;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check1(input string tag, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v;
      int          sz;
      v  = '0;
      sz = size_of(f3);
      for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(addr[9:0]) + i) % 1024];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   task automatic set_word(input logic [31:0] addr, input logic [31:0] w);
      for (int i = 0; i < 4; i++) ref_mem[(int'(addr[9:0]) + i) % 1024] = w[8*i +: 8];
   endtask

   // One complete transaction with resp_ready held high; checks against the model.
   task automatic do_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rd,
                         output logic got_err);
      int          lat;
      int          wc0;
      int          sz;
      logic        legal;
      logic        exp_err;
      logic        ren_s;
      logic [31:0] raddr_s;
      logic [31:0] exp_rd;
      logic [2:0]  exp_wlen;
      @(negedge clk);
      check1("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid  = 1'b1;
      bus.req_wen    = wen;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      wc0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      ren_s   = bus.dmem_ren;
      raddr_s = bus.dmem_raddr;
      lat = 0;
      while (!bus.resp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      got_rd  = bus.resp_rdata;
      got_err = bus.resp_err;

      sz      = size_of(f3);
      legal   = wen ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      exp_err = !legal || ((addr % sz) != 0);
      exp_rd  = (!exp_err && !wen) ? model_load(f3, addr) : 32'h0;
      exp_wlen = (sz == 1) ? 3'b001 : (sz == 2) ? 3'b010 : 3'b100;

      check1("resp_err", got_err, exp_err);
      check("resp_rdata", got_rd, exp_rd);
      check("latency", 32'(lat), exp_err ? 32'd0 : 32'd1);
      check1("dmem_ren", ren_s, !exp_err && !wen);
      check("dmem_raddr", raddr_s, (!exp_err && !wen) ? {addr[31:2], 2'b00} : 32'h0);
      check("write_count", 32'(wr_cnt - wc0), (!exp_err && wen) ? 32'd1 : 32'd0);
      if (!exp_err && wen) begin
         check("dmem_waddr", last_waddr, addr);
         check("dmem_wdata", last_wdata, wdata);
         check("dmem_wlen", 32'(last_wlen), 32'(exp_wlen));
         for (int i = 0; i < sz; i++) ref_mem[(int'(addr[9:0]) + i) % 1024] = wdata[8*i +: 8];
      end
      @(posedge clk);
      #1;
      check1("resp_valid_drop", bus.resp_valid, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] hold_rd;
      int          wc0;
      logic        rw;
      logic [2:0]  rf3;
      logic [31:0] raddr;

      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);

      #12;
      check1("rst_req_ready", bus.req_ready, 1'b0);
      check1("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check1("rst_resp_err", bus.resp_err, 1'b0);
      check1("rst_dmem_ren", bus.dmem_ren, 1'b0);
      check1("rst_dmem_wen", bus.dmem_wen, 1'b0);
      check("rst_dmem_raddr", bus.dmem_raddr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check1("post_rst_req_ready", bus.req_ready, 1'b1);

      set_word(32'h8000_0000, 32'h80FF_1234);
      do_req(1'b0, 3'b000, 32'h8000_0003, 32'h0, rd, er);
      check("lb_value", rd, 32'hFFFF_FF80);

      set_word(32'h8000_0000, 32'hBEEF_0011);
      do_req(1'b0, 3'b101, 32'h8000_0002, 32'h0, rd, er);
      check("lhu_value", rd, 32'h0000_BEEF);
      do_req(1'b0, 3'b001, 32'h8000_0002, 32'h0, rd, er);
      check("lh_value", rd, 32'hFFFF_BEEF);

      do_req(1'b1, 3'b001, 32'h8000_0010, 32'h1234_5678, rd, er);
      check("sh_rdata", rd, 32'h0);
      check("sh_wlen", 32'(last_wlen), 32'h2);
      check("sh_waddr", last_waddr, 32'h8000_0010);
      do_req(1'b0, 3'b000, 32'h8000_0010, 32'h0, rd, er);
      check("sh_readback", rd, 32'h0000_0078);

      do_req(1'b0, 3'b010, 32'h8000_0002, 32'h0, rd, er);
      check1("lw_mis_err", er, 1'b1);
      do_req(1'b1, 3'b011, 32'h8000_0020, 32'hDEAD_BEEF, rd, er);
      check1("st011_err", er, 1'b1);

      // Response back-pressure: a second request must wait for the handshake.
      set_word(32'h8000_0020, 32'hCAFE_F00D);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_wen    = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h8000_0020;
      @(posedge clk);
      #1;
      bus.req_wen    = 1'b1;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h8000_0031;
      bus.req_wdata  = 32'h0000_00A5;
      wc0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check1("hold_resp_valid", bus.resp_valid, 1'b1);
         check("hold_resp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
         check1("hold_req_ready", bus.req_ready, 1'b0);
      end
      check("hold_no_write", 32'(wr_cnt - wc0), 32'd0);
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check1("handshake_resp_valid", bus.resp_valid, 1'b0);
      check1("handshake_req_ready", bus.req_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check1("queued_store_wen", bus.dmem_wen, 1'b1);
      check("queued_store_waddr", bus.dmem_waddr, 32'h8000_0031);
      @(posedge clk);
      #1;
      check("queued_store_count", 32'(wr_cnt - wc0), 32'd1);
      ref_mem[10'h031] = 8'hA5;
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a store.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_wen    = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h8000_0040;
      bus.req_wdata  = 32'h1111_2222;
      wc0 = wr_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check1("abort_wen_before", bus.dmem_wen, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check1("abort_wen_now", bus.dmem_wen, 1'b0);
      check1("abort_resp_valid", bus.resp_valid, 1'b0);
      check1("abort_req_ready", bus.req_ready, 1'b0);
      @(posedge clk);
      #1;
      check("abort_no_write", 32'(wr_cnt - wc0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check1("abort_release_ready", bus.req_ready, 1'b1);
      check1("abort_release_valid", bus.resp_valid, 1'b0);
      hold_rd = model_load(3'b010, 32'h8000_0040);
      do_req(1'b0, 3'b010, 32'h8000_0040, 32'h0, rd, er);
      check("abort_mem_intact", rd, hold_rd);

      for (int n = 0; n < 60; n++) begin
         rw    = 1'($urandom_range(0, 1));
         rf3   = 3'($urandom_range(0, 7));
         raddr = 32'h8000_0000 + 32'($urandom_range(0, 1020));
         if ($urandom_range(0, 1) == 0) raddr[1:0] = 2'b00;
         do_req(rw, rf3, raddr, $urandom, rd, er);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
